// File: rtl/reg_wb_queue.sv
// Writeback queue in front of the register-file write port, with read bypass.
// Optional WB_COALESCE_EN: same-address requests merge into the tail entry.
module reg_wb_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [4:0]    in_addr,
  input  logic [31:0]   in_data,
  input  logic          hold,
  output logic          w_en,
  output logic [4:0]    A3,
  output logic [31:0]   WD3,
  input  logic [4:0]    A1,
  input  logic [4:0]    A2,
  input  logic [31:0]   RD1,
  input  logic [31:0]   RD2,
  output logic [31:0]   RD1_fwd,
  output logic [31:0]   RD2_fwd,
  output logic [AW:0]   count
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_C   = (AW+1)'(1);

  logic [4:0]    addr_q [DEPTH];
  logic [4:0]    addr_d [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [31:0]   data_d [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          w_en_q, w_en_d;
  logic [4:0]    a3_q, a3_d;
  logic [31:0]   wd3_q, wd3_d;

  logic [AW-1:0] tail_ptr;
  logic          pop;
  logic          coal;
  logic          accept;
  logic          push;

  assign tail_ptr = wr_ptr_q - 1'b1;
  assign pop      = (count_q != '0) && !hold;

`ifdef WB_COALESCE_EN
  // A tail that is also the head being popped cannot be merged into.
  assign coal = in_valid && (in_addr != 5'd0)
             && (count_q != '0)
             && (addr_q[tail_ptr] == in_addr)
             && !(pop && (count_q == ONE_C));
  assign in_ready = (count_q < DEPTH_C) || coal;
`else
  assign coal     = 1'b0;
  assign in_ready = (count_q < DEPTH_C);
`endif

  assign accept = in_valid && in_ready;
  assign push   = accept && (in_addr != 5'd0) && !coal;

  always_comb begin
    addr_d   = addr_q;
    data_d   = data_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    w_en_d   = pop;
    a3_d     = a3_q;
    wd3_d    = wd3_q;
    if (push) begin
      addr_d[wr_ptr_q] = in_addr;
      data_d[wr_ptr_q] = in_data;
      wr_ptr_d         = wr_ptr_q + 1'b1;
    end
    if (accept && coal) begin
      data_d[tail_ptr] = in_data;
    end
    if (pop) begin
      a3_d     = addr_q[rd_ptr_q];
      wd3_d    = data_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_comb begin
    count_d = count_q;
    unique case (1'b1)
      push && !pop: count_d = count_q + ONE_C;
      pop && !push: count_d = count_q - ONE_C;
      default:      count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      w_en_q   <= 1'b0;
      a3_q     <= '0;
      wd3_q    <= '0;
    end else begin
      addr_q   <= addr_d;
      data_q   <= data_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      w_en_q   <= w_en_d;
      a3_q     <= a3_d;
      wd3_q    <= wd3_d;
    end
  end

  // Walk oldest to youngest so the youngest match overrides.
  logic [AW-1:0] idx;
  logic [31:0]   fwd1, fwd2;

  always_comb begin
    idx  = rd_ptr_q;
    fwd1 = (w_en_q && (a3_q == A1)) ? wd3_q : RD1;
    fwd2 = (w_en_q && (a3_q == A2)) ? wd3_q : RD2;
    for (int j = 0; j < DEPTH; j++) begin
      idx = rd_ptr_q + AW'(j);
      if (((AW+1)'(j) < count_q) && (addr_q[idx] == A1)) begin
        fwd1 = data_q[idx];
      end
      if (((AW+1)'(j) < count_q) && (addr_q[idx] == A2)) begin
        fwd2 = data_q[idx];
      end
    end
    if (A1 == 5'd0) begin
      fwd1 = '0;
    end
    if (A2 == 5'd0) begin
      fwd2 = '0;
    end
  end

  assign RD1_fwd = fwd1;
  assign RD2_fwd = fwd2;
  assign w_en    = w_en_q;
  assign A3      = a3_q;
  assign WD3     = wd3_q;
  assign count   = count_q;

endmodule
